// File: rtl/sudoku_board_reader.sv
// Streams the solved 81-cell board out of the solver cell memory in row-major order,
// and checks rows, columns, boxes and value range while the cells go past.
module sudoku_board_reader #(
  parameter int CELLS  = 81,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_cell_valid,
  input  logic              i_cell_ready,
  output logic [DATA_W-1:0] o_cell_data,
  output logic [3:0]        o_cell_row,
  output logic [3:0]        o_cell_col,
  output logic              o_cell_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_check_ok,
  output logic              o_err_zero
);

  // Output beat handshake: a beat moves when o_cell_valid and i_cell_ready are both
  // high at a rising edge; while valid is high and ready low the beat holds unchanged.
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] rd_ptr;
  logic [3:0]        frow, fcol;
  logic [80:0]       row_mask, col_mask, box_mask;
  logic              err_any;
  logic              xfer, fetch;
  logic [DATA_W-1:0] vm1;
  logic [3:0]        brow, bcol, box;
  logic [6:0]        ri, ci, bi;
  logic              v_zero, v_big, dup;

  assign xfer  = o_cell_valid & i_cell_ready;
  assign fetch = (state == LOAD) || ((state == STREAM) && xfer && (rd_ptr <= LAST_ADDR));

  assign o_rd_en   = fetch;
  assign o_busy    = (state == LOAD) || (state == STREAM);
  assign o_done    = (state == DONE);
  // rd_ptr parks at CELLS once the last cell is fetched; the address stays on the last cell.
  assign o_rd_addr = (rd_ptr > LAST_ADDR) ? LAST_ADDR : rd_ptr;

  // Checker indices: flat bit index = group*9 + (value-1).
  assign vm1    = i_rd_data - DATA_W'(1);
  assign brow   = (frow < 4'd3) ? 4'd0 : (frow < 4'd6) ? 4'd1 : 4'd2;
  assign bcol   = (fcol < 4'd3) ? 4'd0 : (fcol < 4'd6) ? 4'd1 : 4'd2;
  assign box    = brow * 4'd3 + bcol;
  assign ri     = 7'(frow) * 7'd9 + 7'(vm1);
  assign ci     = 7'(fcol) * 7'd9 + 7'(vm1);
  assign bi     = 7'(box) * 7'd9 + 7'(vm1);
  assign v_zero = (i_rd_data == '0);
  assign v_big  = (i_rd_data > DATA_W'(9));
  assign dup    = row_mask[ri] | col_mask[ci] | box_mask[bi];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_start) state_nx = LOAD;
      LOAD:    state_nx = STREAM;
      STREAM:  if (xfer && o_cell_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      frow         <= '0;
      fcol         <= '0;
      row_mask     <= '0;
      col_mask     <= '0;
      box_mask     <= '0;
      err_any      <= 1'b0;
      o_err_zero   <= 1'b0;
      o_check_ok   <= 1'b0;
      o_cell_valid <= 1'b0;
      o_cell_data  <= '0;
      o_cell_row   <= '0;
      o_cell_col   <= '0;
      o_cell_last  <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && i_start) begin
        rd_ptr     <= '0;
        frow       <= '0;
        fcol       <= '0;
        row_mask   <= '0;
        col_mask   <= '0;
        box_mask   <= '0;
        err_any    <= 1'b0;
        o_err_zero <= 1'b0;
        o_check_ok <= 1'b0;
      end
      if (fetch) begin
        o_cell_data  <= i_rd_data;
        o_cell_row   <= frow;
        o_cell_col   <= fcol;
        o_cell_last  <= (rd_ptr == LAST_ADDR);
        o_cell_valid <= 1'b1;
        rd_ptr       <= rd_ptr + 1'b1;
        if (fcol == 4'd8) begin
          fcol <= '0;
          frow <= frow + 4'd1;
        end else begin
          fcol <= fcol + 4'd1;
        end
        if (v_zero) begin
          o_err_zero <= 1'b1;
          err_any    <= 1'b1;
        end else if (v_big) begin
          err_any <= 1'b1;
        end else begin
          if (dup) err_any <= 1'b1;
          row_mask[ri] <= 1'b1;
          col_mask[ci] <= 1'b1;
          box_mask[bi] <= 1'b1;
        end
      end else if ((state == STREAM) && xfer && o_cell_last) begin
        // The last fetch happened at an earlier edge, so err_any is final here.
        o_cell_valid <= 1'b0;
        o_check_ok   <= ~err_any;
      end
    end
  end

endmodule

// File: tb/tb_sudoku_board_reader.sv
// Directed bench for sudoku_board_reader: expected beats are queued when a read-out
// is started and popped as the DUT hands each beat over.
module tb_sudoku_board_reader;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic [6:0] o_rd_addr;
  logic       o_rd_en;
  logic [3:0] i_rd_data;
  logic       o_cell_valid;
  logic       i_cell_ready;
  logic [3:0] o_cell_data;
  logic [3:0] o_cell_row;
  logic [3:0] o_cell_col;
  logic       o_cell_last;
  logic       o_busy;
  logic       o_done;
  logic       o_check_ok;
  logic       o_err_zero;

  logic [3:0]  mem [81];
  logic [12:0] exp_q [$];
  int          n_vec;
  int          n_err;

  sudoku_board_reader #(.CELLS(81), .ADDR_W(7), .DATA_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .o_rd_addr    (o_rd_addr),
    .o_rd_en      (o_rd_en),
    .i_rd_data    (i_rd_data),
    .o_cell_valid (o_cell_valid),
    .i_cell_ready (i_cell_ready),
    .o_cell_data  (o_cell_data),
    .o_cell_row   (o_cell_row),
    .o_cell_col   (o_cell_col),
    .o_cell_last  (o_cell_last),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_check_ok   (o_check_ok),
    .o_err_zero   (o_err_zero)
  );

  assign i_rd_data = (o_rd_addr < 7'd81) ? mem[o_rd_addr] : 4'd0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, {5'd0, o_rd_addr, o_rd_en, o_cell_valid, o_cell_data, o_cell_row,
                o_cell_col, o_cell_last, o_busy, o_done, o_check_ok, o_err_zero}, 32'd0);
  endtask

  // Legal solution: shifted-row pattern.
  task automatic load_valid();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        mem[r*9+c] = 4'(((r*3 + r/3 + c) % 9) + 1);
  endtask

  // mode 1: ready held high; mode 3: ready high one cycle in three.
  task automatic run_stream(input int mode, input bit mid_start, input int abort_at,
                            input bit exp_ok, input bit exp_zero);
    int          t;
    int          beats;
    int          fetches;
    bit          stall;
    bit          done_seen;
    logic [12:0] held;
    logic [12:0] got;
    logic [12:0] exp;
    exp_q.delete();
    for (int k = 0; k < 81; k++)
      exp_q.push_back({mem[k], 4'(k/9), 4'(k%9), (k == 80)});
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start   = 1'b0;
    t         = 0;
    beats     = 0;
    fetches   = 0;
    stall     = 1'b0;
    done_seen = 1'b0;
    held      = '0;
    while (t < 1000 && !done_seen && beats != abort_at) begin
      @(negedge clk);
      i_cell_ready = (mode == 1) ? 1'b1 : (t % 3 == 0);
      i_start      = mid_start && (t == 20);
      #1;
      if (o_rd_en) begin
        check("rd_addr", 32'(o_rd_addr), 32'(fetches));
        fetches++;
      end
      got = {o_cell_data, o_cell_row, o_cell_col, o_cell_last};
      if (stall && o_cell_valid) check("hold_stable", 32'(got), 32'(held));
      stall = o_cell_valid && !i_cell_ready;
      held  = got;
      if (o_cell_valid && i_cell_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(beats), 32'd81);
        end else begin
          exp = exp_q.pop_front();
          check("beat", 32'(got), 32'(exp));
        end
        beats++;
      end
      if (o_done) begin
        done_seen = 1'b1;
        if (mode == 1) check("done_latency", 32'(t), 32'd82);
        check("beat_count", 32'(beats), 32'd81);
        check("fetch_count", 32'(fetches), 32'd81);
        check("busy_in_done", 32'(o_busy), 32'd0);
        check("check_ok", 32'(o_check_ok), 32'(exp_ok));
        check("err_zero", 32'(o_err_zero), 32'(exp_zero));
      end
      t++;
    end
    i_start      = 1'b0;
    i_cell_ready = 1'b0;
    if (!done_seen && beats != abort_at) check("timeout", 32'(t), 32'd0);
    if (done_seen) begin
      @(negedge clk);
      check("done_pulse_one_cycle", 32'(o_done), 32'd0);
      check("check_ok_held", 32'(o_check_ok), 32'(exp_ok));
    end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    i_start      = 1'b0;
    i_cell_ready = 1'b0;
    load_valid();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset_outputs");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_not_busy", 32'(o_busy), 32'd0);

    // Legal board, ready always high
    run_stream(1, 1'b0, -1, 1'b1, 1'b0);

    // Legal board, back-pressure
    run_stream(3, 1'b0, -1, 1'b1, 1'b0);

    // Cells 0 and 1 swapped: column duplicates only
    load_valid();
    mem[0] = mem[1];
    mem[1] = 4'd1;
    run_stream(1, 1'b0, -1, 1'b0, 1'b0);

    // Unsolved centre cell
    load_valid();
    mem[40] = 4'd0;
    run_stream(1, 1'b0, -1, 1'b0, 1'b1);

    // Out-of-range last cell
    load_valid();
    mem[80] = 4'hA;
    run_stream(1, 1'b0, -1, 1'b0, 1'b0);

    // Reset mid-stream, then a full restart with a stray start pulse while streaming
    load_valid();
    run_stream(1, 1'b0, 30, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outs("reset_mid_stream");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset_held");
    rst = 1'b0;
    run_stream(1, 1'b1, -1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
